// File: rtl/bsa_pkg.sv
// Shared types and helpers for the bit-serial adder.
package bsa_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int cnt_w(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Gate-level full-adder cell: the single bit slice reused on every serial step.
module serial_fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic carry
);

   wire logic w_axb;
   wire logic w_ab;
   wire logic w_cab;

   xor g_x0 (w_axb, a, b);
   xor g_x1 (sum, w_axb, cin);
   and g_a0 (w_ab, a, b);
   and g_a1 (w_cab, w_axb, cin);
   or  g_o0 (carry, w_ab, w_cab);

endmodule

// File: rtl/bit_serial_adder.sv
// Multi-cycle LSB-first adder with start/busy/done handshake.
// Optional signed-overflow output enabled by defining BSA_OVERFLOW_EN.
module bit_serial_adder
   import bsa_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
`ifdef BSA_OVERFLOW_EN
   output logic             cout,
   output logic             ovf
`else
   output logic             cout
`endif
);

   localparam int             CW   = cnt_w(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-1:0] r_sum_sr;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;

   logic             w_s;
   logic             w_c;
   logic [WIDTH-1:0] w_sum_next;

   serial_fa_cell u_fa (
      .a     (r_a_sr[0]),
      .b     (r_b_sr[0]),
      .cin   (r_carry),
      .sum   (w_s),
      .carry (w_c)
   );

   assign w_sum_next = {w_s, r_sum_sr[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_a_sr   <= '0;
         r_b_sr   <= '0;
         r_sum_sr <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
`ifdef BSA_OVERFLOW_EN
         ovf      <= 1'b0;
`endif
      end else begin
         case (r_state)
            // DONE accepts a new start exactly like IDLE, giving back-to-back ops
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  r_a_sr   <= a;
                  r_b_sr   <= b;
                  r_carry  <= cin;
                  r_cnt    <= '0;
                  r_sum_sr <= '0;
                  busy     <= 1'b1;
                  r_state  <= RUN;
               end else begin
                  r_state  <= IDLE;
               end
            end
            RUN: begin
               r_sum_sr <= w_sum_next;
               r_a_sr   <= r_a_sr >> 1;
               r_b_sr   <= r_b_sr >> 1;
               r_carry  <= w_c;
               if (r_cnt == LAST) begin
                  sum     <= w_sum_next;
                  cout    <= w_c;
`ifdef BSA_OVERFLOW_EN
                  // r_carry here is the carry into the MSB slice
                  ovf     <= r_carry ^ w_c;
`endif
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
               end
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder (WIDTH=8); define BSA_OVERFLOW_EN to also check ovf.
module tb_bit_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef BSA_OVERFLOW_EN
   logic         ovf;
`endif

   bit_serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
`ifdef BSA_OVERFLOW_EN
      .cout  (cout),
      .ovf   (ovf)
`else
      .cout  (cout)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Reference model: plain integer arithmetic on the operands.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, input int due);
      exp_t e;
      int   full;
      int   sx;
      int   sy;
      int   ss;
      full   = int'(x) + int'(y) + int'(ci);
      e.sum  = W'(full % (1 << W));
      e.cout = (full >= (1 << W));
      sx     = x[W-1] ? int'(x) - (1 << W) : int'(x);
      sy     = y[W-1] ? int'(y) - (1 << W) : int'(y);
      ss     = sx + sy + int'(ci);
      e.ovf  = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
      e.cyc  = due;
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: done=1 with no op outstanding (t=%0t)", $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sum", 64'(sum), 64'(e.sum));
            chk("cout", 64'(cout), 64'(e.cout));
`ifdef BSA_OVERFLOW_EN
            chk("ovf", 64'(ovf), 64'(e.ovf));
`endif
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   // Each uninterrupted busy run must last exactly W cycles.
   int bsy_run = 0;
   always @(negedge clk) begin
      if (rst) bsy_run = 0;
      else if (busy) bsy_run++;
      else if (bsy_run != 0) begin
         chk("busy_len", 64'(bsy_run), 64'(W));
         bsy_run = 0;
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 40; i++) begin
         if (!busy) return;
         @(negedge clk);
      end
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: busy=%0b, expected 0 within 40 cycles", busy);
   endtask

   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      a     = x;
      b     = y;
      cin   = ci;
      start = 1'b1;
      exp_q.push_back(model(x, y, ci, cyc + 1 + W));
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom);
   endtask

   task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      wait_idle();
      issue(x, y, ci);
   endtask

   task automatic drain();
      for (int i = 0; i < 60; i++) begin
         if (exp_q.size() == 0) return;
         @(negedge clk);
      end
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
   endtask

   initial begin
      bit got;
      rst   = 1'b1;
      start = 1'b1;
      a     = 8'h12;
      b     = 8'h34;
      cin   = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_sum", 64'(sum), 64'd0);
      chk("rst_cout", 64'(cout), 64'd0);
      start = 1'b0;
      rst   = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", 64'(busy), 64'd0);

      do_op(8'h0F, 8'h01, 1'b0);
      drain();
      do_op(8'hFF, 8'h01, 1'b0);
      drain();
      do_op(8'h7F, 8'h00, 1'b1);
      drain();

      // Start while busy is ignored; new start in the DONE cycle runs back to back.
      do_op(8'hFF, 8'hFF, 1'b1);
      repeat (3) @(negedge clk);
      a     = 8'h01;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!got) begin
         n_vec++;
         n_err++;
         $display("FAIL b2b_done_timeout: done never seen, expected a pulse");
      end else begin
         issue(8'h02, 8'h03, 1'b0);
         chk("b2b_busy_no_gap", 64'(busy), 64'd1);
      end
      drain();

      // Abort in RUN cycle 3.
      do_op(8'h55, 8'h66, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_sum", 64'(sum), 64'd0);
      chk("abort_cout", 64'(cout), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      do_op(8'h0A, 8'h05, 1'b0);
      drain();

      for (int k = 0; k < 24; k++) begin
         do_op(W'($urandom), W'($urandom), 1'($urandom));
         if ($urandom_range(1, 0) == 0) drain();
      end
      drain();
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
